// File: rtl/lcd_pkg.sv
// Shared constants, state enums and helpers for the LCD refresh sequencer.
package lcd_pkg;

  localparam logic [7:0] CmdFuncSet  = 8'h38;
  localparam logic [7:0] CmdDispOn   = 8'h0C;
  localparam logic [7:0] CmdEntry    = 8'h06;
  localparam logic [7:0] CmdClear    = 8'h01;
  localparam logic [7:0] CmdSetDdram = 8'h80;
  localparam logic [7:0] AsciiZero   = 8'h30;
  localparam logic [7:0] AsciiSpace  = 8'h20;

  typedef enum logic [2:0] {StPwrup, StInit, StIdle, StAddr, StData} top_st_e;
  typedef enum logic [1:0] {PhIdle, PhSetup, PhPulse, PhWait} byte_ph_e;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CmdFuncSet;
      2'd1:    cmd = CmdDispOn;
      2'd2:    cmd = CmdEntry;
      default: cmd = CmdClear;
    endcase
    return cmd;
  endfunction

  // Index 4 is the ten-thousands digit; index 0 is never blanked.
  function automatic logic [4:0][7:0] blank_leading(input logic [4:0][7:0] c);
    logic [4:0][7:0] r;
    logic            lead;
    r    = c;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && (c[i] == AsciiZero)) begin
        r[i] = AsciiSpace;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_refresh_sequencer_if.sv
// Request/character inputs and LCD pin outputs of the refresh sequencer.
interface lcd_refresh_sequencer_if;
  logic       start;
  logic [7:0] char4;
  logic [7:0] char3;
  logic [7:0] char2;
  logic [7:0] char1;
  logic [7:0] char0;
  logic       busy;
  logic       done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  modport master (
    output start, char4, char3, char2, char1, char0,
    input  busy, done, lcd_rs, lcd_rw, lcd_e, lcd_data
  );

  modport slave (
    input  start, char4, char3, char2, char1, char0,
    output busy, done, lcd_rs, lcd_rw, lcd_e, lcd_data
  );
endinterface

// File: rtl/lcd_byte_writer.sv
// Drives one LCD byte write: SETUP (E low), PULSE (E high), WAIT (E low).
// ready is high when idle or in the final WAIT cycle, so bytes chain with no gap.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned E_PULSE_CYC  = 12,
  parameter int unsigned WAIT_CYC     = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000,
  parameter int unsigned CntW         = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       lcd_rs_o,
  output logic       lcd_e_o,
  output logic [7:0] lcd_data_o,
  output logic       ready_o
);

  byte_ph_e        phase_q, phase_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rs_q, rs_d;
  logic            e_q, e_d;
  logic [7:0]      data_q, data_d;
  logic            long_q, long_d;
  logic            wait_last;

  assign wait_last = (cnt_q == (long_q ? CntW'(CLR_WAIT_CYC - 1) : CntW'(WAIT_CYC - 1)));
  assign ready_o   = (phase_q == PhIdle) || ((phase_q == PhWait) && wait_last);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    e_d     = e_q;
    data_d  = data_q;
    long_d  = long_q;
    unique case (phase_q)
      PhSetup: begin
        if (cnt_q == CntW'(SETUP_CYC - 1)) begin
          phase_d = PhPulse;
          cnt_d   = '0;
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      PhPulse: begin
        if (cnt_q == CntW'(E_PULSE_CYC - 1)) begin
          phase_d = PhWait;
          cnt_d   = '0;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        if (!ready_o) begin
          cnt_d = cnt_q + CntW'(1);
        end else if (go_i) begin
          phase_d = PhSetup;
          cnt_d   = '0;
          rs_d    = rs_i;
          data_d  = data_i;
          long_d  = long_wait_i;
        end else begin
          phase_d = PhIdle;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= PhIdle;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  assign lcd_rs_o   = rs_q;
  assign lcd_e_o    = e_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// Power-on init then address + five digit writes per refresh on an HD44780 bus.
// Define LCD_LEADING_BLANK_EN to blank leading '0' digits (char4..char1) at latch time.
module lcd_refresh_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC  = 20,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned E_PULSE_CYC  = 12,
  parameter int unsigned WAIT_CYC     = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000,
  parameter logic [6:0]  START_ADDR   = 7'h00
) (
  input logic                    clk,
  input logic                    rst,
  lcd_refresh_sequencer_if.slave bus
);

  localparam int unsigned MaxCyc = (POWERUP_CYC > CLR_WAIT_CYC) ? POWERUP_CYC : CLR_WAIT_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  top_st_e         st_q, st_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] pcnt_q, pcnt_d;
  logic [4:0][7:0] ch_q, ch_d;
  logic [4:0][7:0] ch_raw;
  logic            wr_go, wr_rs, wr_long, wr_ready;
  logic [7:0]      wr_data;

  assign ch_raw = {bus.char4, bus.char3, bus.char2, bus.char1, bus.char0};

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    ch_d    = ch_q;
    wr_go   = 1'b0;
    wr_rs   = 1'b0;
    wr_long = 1'b0;
    wr_data = 8'h00;
    unique case (st_q)
      StPwrup: begin
        if (pcnt_q == CntW'(POWERUP_CYC - 1)) begin
          wr_go   = 1'b1;
          wr_data = init_cmd(2'd0);
          st_d    = StInit;
          idx_d   = 3'd0;
        end else begin
          pcnt_d = pcnt_q + CntW'(1);
        end
      end
      StInit: begin
        if (wr_ready) begin
          if (idx_q == 3'd3) begin
            st_d = StIdle;
          end else begin
            wr_go   = 1'b1;
            wr_data = init_cmd(idx_q[1:0] + 2'd1);
            wr_long = (idx_q == 3'd2);
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      StIdle: begin
        if (bus.start) begin
`ifdef LCD_LEADING_BLANK_EN
          ch_d = blank_leading(ch_raw);
`else
          ch_d = ch_raw;
`endif
          wr_go   = 1'b1;
          wr_data = CmdSetDdram | {1'b0, START_ADDR};
          st_d    = StAddr;
        end
      end
      StAddr: begin
        if (wr_ready) begin
          wr_go   = 1'b1;
          wr_rs   = 1'b1;
          wr_data = ch_q[4];
          st_d    = StData;
          idx_d   = 3'd0;
        end
      end
      StData: begin
        if (wr_ready) begin
          if (idx_q == 3'd4) begin
            st_d = StIdle;
          end else begin
            wr_go   = 1'b1;
            wr_rs   = 1'b1;
            wr_data = ch_q[3'd3 - idx_q];
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      default: st_d = StPwrup;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q   <= StPwrup;
      idx_q  <= 3'd0;
      pcnt_q <= '0;
      ch_q   <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      pcnt_q <= pcnt_d;
      ch_q   <= ch_d;
    end
  end

  lcd_byte_writer #(
    .SETUP_CYC    (SETUP_CYC),
    .E_PULSE_CYC  (E_PULSE_CYC),
    .WAIT_CYC     (WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC),
    .CntW         (CntW)
  ) u_writer (
    .clk         (clk),
    .rst         (rst),
    .go_i        (wr_go),
    .rs_i        (wr_rs),
    .data_i      (wr_data),
    .long_wait_i (wr_long),
    .lcd_rs_o    (bus.lcd_rs),
    .lcd_e_o     (bus.lcd_e),
    .lcd_data_o  (bus.lcd_data),
    .ready_o     (wr_ready)
  );

  // The done cycle is the final WAIT cycle of char0, where busy already reads low.
  assign bus.done   = (st_q == StData) && (idx_q == 3'd4) && wr_ready;
  assign bus.busy   = (st_q != StIdle) && !bus.done;
  assign bus.lcd_rw = 1'b0;

endmodule
